// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NREQ producers, the round-robin arbiter and a sync FIFO.
// The arbiter takes the master view: it owns the FIFO write port and the grant/ack returns.
interface fifo_wr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    gnt;
  logic               fifo_fullp;
  logic               fifo_writep;
  logic [DW-1:0]      fifo_din;
  logic               stall_drop;

  modport master (
    input  req, req_data, fifo_fullp,
    output ack, gnt, fifo_writep, fifo_din, stall_drop
  );

  modport slave (
    output req, req_data, fifo_fullp,
    input  ack, gnt, fifo_writep, fifo_din, stall_drop
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, with
// per-grant burst limit and forced release of a grant stalled on a full FIFO.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 16,
  parameter int BURST     = 4,
  parameter int STALL_MAX = 8
) (
  input  logic               clk,
  input  logic               rstn,
  fifo_wr_arbiter_if.master  bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(BURST + 1);
  localparam int SW = $clog2(STALL_MAX + 1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   owner, rr_ptr, sel;
  logic [NREQ-1:0] gnt_q;
  logic [BW-1:0]   burst_cnt;
  logic [SW-1:0]   stall_cnt;
  logic            found, owner_req, write, stalled, timeout;

  // First requester at or after rr_ptr, wrapping round.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && bus.req[(int'(rr_ptr) + i) % NREQ]) begin
        found = 1'b1;
        sel   = PW'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end

  assign owner_req = bus.req[owner];
  assign bus.gnt   = gnt_q;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt       = state;
    write           = 1'b0;
    stalled         = 1'b0;
    timeout         = 1'b0;
    bus.ack         = '0;
    bus.fifo_writep = 1'b0;
    bus.fifo_din    = '0;
    bus.stall_drop  = 1'b0;
    unique case (state)
      IDLE: if (found) state_nxt = GRANT;
      GRANT: begin
        write           = owner_req & ~bus.fifo_fullp;
        stalled         = owner_req & bus.fifo_fullp;
        timeout         = stalled && (stall_cnt == SW'(STALL_MAX - 1));
        bus.fifo_writep = write;
        bus.ack[owner]  = write;
        bus.fifo_din    = bus.req_data[int'(owner)*DW +: DW];
        bus.stall_drop  = timeout;
        if (!owner_req || timeout || (write && burst_cnt == BW'(BURST - 1)))
          state_nxt = RELEASE;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge, regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      gnt_q     <= '0;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (found) begin
          gnt_q     <= NREQ'(1) << sel;
          owner     <= sel;
          burst_cnt <= '0;
          stall_cnt <= '0;
        end
        GRANT: begin
          if (write) begin
            burst_cnt <= burst_cnt + 1'b1;
            stall_cnt <= '0;
          end else if (stalled) begin
            stall_cnt <= stall_cnt + 1'b1;
          end
          if (state_nxt == RELEASE) gnt_q <= '0;
        end
        // The releasing requester drops to lowest priority for the next round.
        RELEASE: rr_ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, every cycle
// compared against a transaction-level model of grants, bursts and stalls.
module tb_fifo_wr_arbiter;
  localparam int NREQ      = 4;
  localparam int DW        = 16;
  localparam int BURST     = 4;
  localparam int STALL_MAX = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DW(DW), .BURST(BURST), .STALL_MAX(STALL_MAX)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Producers
  logic [NREQ-1:0] want;
  logic [DW-1:0]   data [NREQ];
  int              words_left [NREQ];
  logic [NREQ-1:0] last_ack;
  logic            full;

  // Reference model: who holds the grant, words written and consecutive stalls
  // in this grant, the cycles still to wait before arbitrating, and the priority start.
  int m_owner, m_ptr, m_gap, m_words, m_stall;

  // Tallies observed on the DUT within one scenario
  int              t_writes, t_drops;
  logic [NREQ-1:0] grants[$];
  logic [NREQ-1:0] prev_gnt;

  task automatic clear_tally();
    t_writes = 0;
    t_drops  = 0;
    grants.delete();
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_gap = 0; m_words = 0; m_stall = 0;
    want = '0; last_ack = '0; full = 1'b0; prev_gnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      data[i] = '0;
      words_left[i] = 0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i] = want[i];
      bus.req_data[i*DW +: DW] = data[i];
    end
    bus.fifo_fullp = full;
  endtask

  task automatic step_check();
    logic [NREQ-1:0] exp_gnt, exp_ack;
    logic [DW-1:0]   exp_din;
    logic            exp_wr, exp_drop, rq;
    exp_gnt = '0; exp_ack = '0; exp_din = '0; exp_wr = 1'b0; exp_drop = 1'b0; rq = 1'b0;
    if (m_owner >= 0) begin
      rq = want[m_owner];
      exp_gnt[m_owner] = 1'b1;
      exp_din  = data[m_owner];
      exp_wr   = rq && !full;
      exp_ack[m_owner] = exp_wr;
      exp_drop = rq && full && (m_stall == STALL_MAX - 1);
    end
    check("gnt",         64'(bus.gnt),         64'(exp_gnt));
    check("ack",         64'(bus.ack),         64'(exp_ack));
    check("fifo_writep", 64'(bus.fifo_writep), 64'(exp_wr));
    check("fifo_din",    64'(bus.fifo_din),    64'(exp_din));
    check("stall_drop",  64'(bus.stall_drop),  64'(exp_drop));

    t_writes += int'(bus.fifo_writep);
    t_drops  += int'(bus.stall_drop);
    if (bus.gnt != '0 && prev_gnt == '0) grants.push_back(bus.gnt);
    prev_gnt = bus.gnt;

    if (m_owner >= 0) begin
      if (exp_wr) begin
        m_words++;
        m_stall = 0;
      end else if (rq) begin
        m_stall++;
      end
      if (!rq || exp_drop || (exp_wr && m_words == BURST)) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
        m_gap   = 1;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (m_owner < 0 && want[(m_ptr + k) % NREQ]) begin
          m_owner = (m_ptr + k) % NREQ;
          m_words = 0;
          m_stall = 0;
        end
      end
    end
    last_ack = exp_ack;
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 again.
  task automatic run_cycles(input int n, input logic [NREQ-1:0] allow, input int p_req,
                            input int fixed_words, input int p_full);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        logic done;
        done = 1'b0;
        if (last_ack[i]) begin
          data[i] = DW'($urandom);
          words_left[i]--;
          if (words_left[i] == 0) begin
            want[i] = 1'b0;
            done = 1'b1;
          end
        end
        if (!want[i] && !done && allow[i] && int'($urandom_range(99, 0)) < p_req) begin
          want[i] = 1'b1;
          data[i] = DW'($urandom);
          words_left[i] = (fixed_words > 0) ? fixed_words : int'($urandom_range(6, 1));
        end
      end
      last_ack = '0;
      full = int'($urandom_range(99, 0)) < p_full;
      drive();
      @(negedge clk);
      step_check();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    drive();
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    model_reset();
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt",   64'(bus.gnt),         64'(0));
    check("rst_ack",   64'(bus.ack),         64'(0));
    check("rst_wr",    64'(bus.fifo_writep), 64'(0));
    check("rst_din",   64'(bus.fifo_din),    64'(0));
    check("rst_drop",  64'(bus.stall_drop),  64'(0));
    rstn = 1'b1;

    // Single burst from requester 2
    clear_tally();
    run_cycles(7, 4'b0100, 100, 4, 0);
    check("t2_writes", 64'(t_writes), 64'(4));
    check("t2_grant0", 64'(grants.size() > 0 ? grants[0] : '0), 64'(4'b0100));
    run_cycles(8, 4'b0000, 0, 4, 0);

    // Asynchronous reset in the middle of requester 0's grant
    run_cycles(3, 4'b0001, 100, 15, 0);
    rstn = 1'b0;
    #1;
    check("t1_gnt",  64'(bus.gnt),         64'(0));
    check("t1_ack",  64'(bus.ack),         64'(0));
    check("t1_wr",   64'(bus.fifo_writep), 64'(0));
    check("t1_din",  64'(bus.fifo_din),    64'(0));
    model_reset();
    drive();
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Fairness: all four held, priority restarts at 0 after reset
    clear_tally();
    run_cycles(30, 4'b1111, 100, 100, 0);
    check("t3_grants", 64'(grants.size()), 64'(5));
    for (int k = 0; k < 5 && k < grants.size(); k++)
      check($sformatf("t3_order%0d", k), 64'(grants[k]), 64'(4'b0001 << (k % NREQ)));
    check("t3_writes", 64'(t_writes), 64'(20));

    // Full backpressure for 3 cycles mid-burst
    do_reset();
    clear_tally();
    run_cycles(3, 4'b0010, 100, 4, 0);
    check("t4_pre", 64'(t_writes), 64'(2));
    run_cycles(3, 4'b0010, 100, 4, 100);
    check("t4_full", 64'(t_writes), 64'(2));
    run_cycles(6, 4'b0010, 0, 4, 0);
    check("t4_total", 64'(t_writes), 64'(4));
    check("t4_owner", 64'(grants.size()), 64'(1));

    // Stall timeout with FIFO permanently full
    do_reset();
    clear_tally();
    run_cycles(20, 4'b0011, 100, 100, 100);
    check("t5_writes", 64'(t_writes), 64'(0));
    check("t5_drops",  64'(t_drops),  64'(2));
    check("t5_next",   64'(grants.size() > 1 ? grants[1] : '0), 64'(4'b0010));

    // Early drop after two words hands priority to the next requester
    do_reset();
    clear_tally();
    run_cycles(10, 4'b1100, 100, 2, 0);
    check("t6_first",  64'(grants.size() > 0 ? grants[0] : '0), 64'(4'b0100));
    check("t6_second", 64'(grants.size() > 1 ? grants[1] : '0), 64'(4'b1000));
    check("t6_writes", 64'(t_writes), 64'(4));

    // Random traffic with random backpressure
    do_reset();
    run_cycles(3000, 4'b1111, 30, 0, 25);
    run_cycles(1500, 4'b1111, 80, 0, 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
